// File: rtl/serial_mult.sv
//-----------------------------------------------------------------------------
// serial_mult
//
// Iterative shift-add multiplier that consumes one multiplier bit per clock.
// It is used to rebuild products such as quotient*divisor bounds in datapaths
// where area matters more than throughput.
//
// Operation:
//   - Operands are accepted in IDLE.
//   - BUSY runs for exactly WIDTH cycles. There is no early exit.
//   - The product is held in DONE until the consumer takes it.
//   - With out_ready_i tied high, one product completes every WIDTH+2 cycles.
//
// Parameters:
//   WIDTH   operand width in bits (>= 1)
//   SIGNED  0: unsigned operands, 1: two's-complement operands and product
//
// Ports:
//   clk_i        in   1        clock, rising edge
//   rst_i        in   1        synchronous reset, active-high
//   in_valid_i   in   1        operands valid
//   in_ready_o   out  1        block can accept operands (IDLE)
//   a_i          in   WIDTH    multiplicand
//   b_i          in   WIDTH    multiplier
//   out_valid_o  out  1        product valid (DONE)
//   out_ready_i  in   1        consumer accepts product
//   prod_o       out  2*WIDTH  exact product a_i*b_i, registered
//   busy_o       out  1        multiplication in progress (BUSY)
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module serial_mult #(
   parameter int WIDTH  = 32,
   parameter bit SIGNED = 1'b0
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               in_valid_i,
   output logic               in_ready_o,
   input  logic [WIDTH-1:0]   a_i,
   input  logic [WIDTH-1:0]   b_i,
   output logic               out_valid_o,
   input  logic               out_ready_i,
   output logic [2*WIDTH-1:0] prod_o,
   output logic               busy_o
);

   // Index width able to hold values 0..n-1, never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int PW    = 2 * WIDTH;
   localparam int CNT_W = idx_width(WIDTH + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   if (WIDTH < 1) begin : g_bad_width
      $fatal(1, "serial_mult: WIDTH must be >= 1");
   end

   // Unsigned magnitude of an operand.
   // In signed mode the most negative value negates to itself. Read as
   // unsigned, that value is 2^(WIDTH-1), which is its correct magnitude,
   // so WIDTH bits are enough for the magnitude.
   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x);
      if (SIGNED && x[WIDTH-1]) begin
         return WIDTH'(-x);
      end
      return x;
   endfunction

   // Restore the sign of the product. The result is taken mod 2^(2*WIDTH),
   // which is exact because the magnitude product always fits.
   function automatic logic [PW-1:0] apply_sign(input logic [PW-1:0] mag,
                                                input logic            neg);
      return neg ? PW'(-mag) : mag;
   endfunction

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [PW-1:0]     acc_q, acc_d;
   logic [PW-1:0]     mcand_q, mcand_d;
   logic [WIDTH-1:0]  mult_q, mult_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              neg_q, neg_d;
   logic [PW-1:0]     prod_q, prod_d;
   logic [PW-1:0]     acc_sum;

   // Accumulator value after the current BUSY step.
   assign acc_sum = acc_q + (mult_q[0] ? mcand_q : '0);

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      mcand_d = mcand_q;
      mult_d  = mult_q;
      cnt_d   = cnt_q;
      neg_d   = neg_q;
      prod_d  = prod_q;
      case (state_q)
         IDLE: begin
            if (in_valid_i) begin
               acc_d   = '0;
               cnt_d   = '0;
               mcand_d = PW'(magnitude(a_i));
               mult_d  = magnitude(b_i);
               neg_d   = SIGNED ? (a_i[WIDTH-1] ^ b_i[WIDTH-1]) : 1'b0;
               state_d = BUSY;
            end
         end
         BUSY: begin
            acc_d   = acc_sum;
            mcand_d = mcand_q << 1;
            mult_d  = mult_q >> 1;
            cnt_d   = cnt_q + CNT_W'(1);
            // The last step writes the signed result straight into the
            // output register, so DONE presents a stable product.
            if (cnt_q == CNT_LAST) begin
               prod_d  = apply_sign(acc_sum, neg_q);
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready_i) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         acc_q   <= '0;
         mcand_q <= '0;
         mult_q  <= '0;
         cnt_q   <= '0;
         neg_q   <= 1'b0;
         prod_q  <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         mcand_q <= mcand_d;
         mult_q  <= mult_d;
         cnt_q   <= cnt_d;
         neg_q   <= neg_d;
         prod_q  <= prod_d;
      end
   end

   // Handshake outputs are decoded from registered state only.
   assign in_ready_o  = (state_q == IDLE);
   assign out_valid_o = (state_q == DONE);
   assign busy_o      = (state_q == BUSY);
   assign prod_o      = prod_q;

endmodule
